// File: rtl/memory_access_pkg.sv
// Shared definitions for the Y86-64 memory stage:
// icodes, status codes, FSM states and operand selectors.
package memory_access_pkg;

  localparam logic [3:0] IHALT   = 4'd0;
  localparam logic [3:0] INOP    = 4'd1;
  localparam logic [3:0] IRRMOVQ = 4'd2;
  localparam logic [3:0] IIRMOVQ = 4'd3;
  localparam logic [3:0] IRMMOVQ = 4'd4;
  localparam logic [3:0] IMRMOVQ = 4'd5;
  localparam logic [3:0] IOPQ    = 4'd6;
  localparam logic [3:0] IJXX    = 4'd7;
  localparam logic [3:0] ICALL   = 4'd8;
  localparam logic [3:0] IRET    = 4'd9;
  localparam logic [3:0] IPUSHQ  = 4'd10;
  localparam logic [3:0] IPOPQ   = 4'd11;

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MEM,
    S_DONE,
    S_STOP
  } state_e;

  typedef enum logic {
    ADDR_VALE,
    ADDR_VALA
  } addr_sel_e;

  typedef enum logic {
    WDATA_VALA,
    WDATA_VALP
  } wdata_sel_e;

endpackage

// File: rtl/memory_access_mem_op_decode.sv
// Combinational icode decode: access direction,
// address/data operand selection and illegal icode.
module mem_op_decode
  import memory_access_pkg::*;
(
  input  logic [3:0] icode,
  output logic       is_read,
  output logic       is_write,
  output addr_sel_e  addr_sel,
  output wdata_sel_e wdata_sel,
  output logic       invalid
);

  always_comb begin
    is_read   = 1'b0;
    is_write  = 1'b0;
    addr_sel  = ADDR_VALE;
    wdata_sel = WDATA_VALA;
    invalid   = 1'b0;
    unique case (1'b1)
      icode == IRMMOVQ: is_write = 1'b1;
      icode == IMRMOVQ: is_read = 1'b1;
      icode == ICALL: begin
        is_write  = 1'b1;
        wdata_sel = WDATA_VALP;
      end
      icode == IRET: begin
        is_read  = 1'b1;
        addr_sel = ADDR_VALA;
      end
      icode == IPUSHQ: is_write = 1'b1;
      icode == IPOPQ: begin
        is_read  = 1'b1;
        addr_sel = ADDR_VALA;
      end
      icode >= 4'd12: invalid = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// Y86-64 memory stage: one outstanding data-memory
// access per bundle, result handed to writeback.
module memory_access
  import memory_access_pkg::*;
#(
  parameter logic [63:0] ADDR_LIMIT = 64'h1000,
  parameter int          TIMEOUT    = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_icode,
  input  logic [63:0] in_valE,
  input  logic [63:0] in_valA,
  input  logic [63:0] in_valP,
  input  logic        in_cnd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_icode,
  output logic [63:0] out_valE,
  output logic [63:0] out_valM,
  output logic        out_cnd,
  output logic [2:0]  out_stat,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        out_valid_q, out_valid_d;
  logic [3:0]  out_icode_q, out_icode_d;
  logic [63:0] out_valE_q, out_valE_d;
  logic [63:0] out_valM_q, out_valM_d;
  logic        out_cnd_q, out_cnd_d;
  logic [2:0]  out_stat_q, out_stat_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [63:0] mem_addr_q, mem_addr_d;
  logic [63:0] mem_wdata_q, mem_wdata_d;

  logic        is_read, is_write, invalid;
  addr_sel_e   addr_sel;
  wdata_sel_e  wdata_sel;
  logic        mem_op, addr_ok;
  logic [63:0] addr, wdata;

  mem_op_decode u_dec (
    .icode     (in_icode),
    .is_read   (is_read),
    .is_write  (is_write),
    .addr_sel  (addr_sel),
    .wdata_sel (wdata_sel),
    .invalid   (invalid)
  );

  assign mem_op  = is_read | is_write;
  assign addr    = (addr_sel == ADDR_VALA) ? in_valA : in_valE;
  assign wdata   = (wdata_sel == WDATA_VALP) ? in_valP : in_valA;
  assign addr_ok = addr <= (ADDR_LIMIT - 64'd8);

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign out_icode = out_icode_q;
  assign out_valE  = out_valE_q;
  assign out_valM  = out_valM_q;
  assign out_cnd   = out_cnd_q;
  assign out_stat  = out_stat_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_icode_d = out_icode_q;
    out_valE_d  = out_valE_q;
    out_valM_d  = out_valM_q;
    out_cnd_d   = out_cnd_q;
    out_stat_d  = out_stat_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          out_icode_d = in_icode;
          out_valE_d  = in_valE;
          out_cnd_d   = in_cnd;
          out_valM_d  = 64'd0;
          if (mem_op && addr_ok && !invalid) begin
            state_d     = S_MEM;
            cnt_d       = '0;
            mem_req_d   = 1'b1;
            mem_we_d    = is_write;
            mem_addr_d  = addr;
            mem_wdata_d = is_write ? wdata : 64'd0;
          end else begin
            state_d     = S_DONE;
            out_valid_d = 1'b1;
            if (invalid)
              out_stat_d = SINS;
            else if (in_icode == IHALT)
              out_stat_d = SHLT;
            else if (mem_op)
              out_stat_d = SADR;
            else
              out_stat_d = SAOK;
          end
        end
      end
      S_MEM: begin
        // ack wins over a timeout landing in the same cycle
        if (mem_ack) begin
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          out_stat_d  = SAOK;
          out_valM_d  = mem_we_q ? 64'd0 : mem_rdata;
          mem_req_d   = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          out_stat_d  = SADR;
          mem_req_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d = (out_stat_q == SAOK) ? S_IDLE : S_STOP;
        end
      end
      S_STOP: ;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_icode_q <= 4'd0;
      out_valE_q  <= 64'd0;
      out_valM_q  <= 64'd0;
      out_cnd_q   <= 1'b0;
      out_stat_q  <= 3'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 64'd0;
      mem_wdata_q <= 64'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_icode_q <= out_icode_d;
      out_valE_q  <= out_valE_d;
      out_valM_q  <= out_valM_d;
      out_cnd_q   <= out_cnd_d;
      out_stat_q  <= out_stat_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: expected results
// are queued at issue and checked by a separate monitor.
module tb_memory_access;

  typedef struct {
    logic [3:0]  icode;
    logic [63:0] valE;
    logic [63:0] valM;
    logic        cnd;
    logic [2:0]  stat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_icode = 4'd0;
  logic [63:0] in_valE = 64'd0;
  logic [63:0] in_valA = 64'd0;
  logic [63:0] in_valP = 64'd0;
  logic        in_cnd = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [3:0]  out_icode;
  logic [63:0] out_valE;
  logic [63:0] out_valM;
  logic        out_cnd;
  logic [2:0]  out_stat;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [63:0] mem_rdata = 64'd0;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];

  memory_access dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_icode  (in_icode),
    .in_valE   (in_valE),
    .in_valA   (in_valA),
    .in_valP   (in_valP),
    .in_cnd    (in_cnd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_icode (out_icode),
    .out_valE  (out_valE),
    .out_valM  (out_valM),
    .out_cnd   (out_cnd),
    .out_stat  (out_stat),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: one pop per output handshake
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_icode", 64'(out_icode), 64'(e.icode));
        chk("out_valE", out_valE, e.valE);
        chk("out_valM", out_valM, e.valM);
        chk("out_cnd", 64'(out_cnd), 64'(e.cnd));
        chk("out_stat", 64'(out_stat), 64'(e.stat));
      end
    end
  end

  task automatic expect_out(input logic [3:0] ic,
                            input logic [63:0] ve,
                            input logic [63:0] vm,
                            input logic c,
                            input logic [2:0] st);
    exp_t e;
    e.icode = ic;
    e.valE = ve;
    e.valM = vm;
    e.cnd = c;
    e.stat = st;
    sb.push_back(e);
  endtask

  // returns #1 after the accepting edge
  task automatic send(input logic [3:0] ic,
                      input logic [63:0] ve,
                      input logic [63:0] va,
                      input logic [63:0] vp,
                      input logic c);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 64'd0, 64'd1);
    in_valid = 1'b1;
    in_icode = ic;
    in_valE = ve;
    in_valA = va;
    in_valP = vp;
    in_cnd = c;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic ack(input logic [63:0] d);
    mem_rdata = d;
    mem_ack = 1'b1;
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    rst_n = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_stopped(input string tag);
    in_valid = 1'b1;
    in_icode = 4'd6;
    idle_cycles(3);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_mem_req"}, 64'(mem_req), 64'd0);
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    idle_cycles(2);
    do_reset();
    chk("reset_in_ready", 64'(in_ready), 64'd1);

    // OPq: no access, one-cycle latency
    expect_out(4'd6, 64'd5, 64'd0, 1'b1, 3'd1);
    send(4'd6, 64'd5, 64'd0, 64'd0, 1'b1);
    chk("opq_valid", 64'(out_valid), 64'd1);
    chk("opq_no_req", 64'(mem_req), 64'd0);

    // mrmovq, ack in third MEM cycle
    expect_out(4'd5, 64'h100, 64'hDEAD, 1'b0, 3'd1);
    send(4'd5, 64'h100, 64'd0, 64'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("mr_req", 64'(mem_req), 64'd1);
      chk("mr_we", 64'(mem_we), 64'd0);
      chk("mr_addr", mem_addr, 64'h100);
      chk("mr_in_ready", 64'(in_ready), 64'd0);
      if (i < 2) idle_cycles(1);
    end
    ack(64'hDEAD);
    chk("mr_valid", 64'(out_valid), 64'd1);
    chk("mr_req_drop", 64'(mem_req), 64'd0);

    // call writes valP at valE, ack at minimum latency
    expect_out(4'd8, 64'h1F8, 64'd0, 1'b1, 3'd1);
    send(4'd8, 64'h1F8, 64'h77, 64'h40, 1'b1);
    chk("call_we", 64'(mem_we), 64'd1);
    chk("call_addr", mem_addr, 64'h1F8);
    chk("call_wdata", mem_wdata, 64'h40);
    ack(64'h5555);
    chk("call_valid", 64'(out_valid), 64'd1);

    // rmmovq at the last legal quadword
    expect_out(4'd4, 64'hFF8, 64'd0, 1'b0, 3'd1);
    send(4'd4, 64'hFF8, 64'h1234, 64'd0, 1'b0);
    chk("edge_req", 64'(mem_req), 64'd1);
    chk("edge_wdata", mem_wdata, 64'h1234);
    ack(64'd0);

    // ret reads M[valA]
    expect_out(4'd9, 64'h310, 64'hBEEF, 1'b0, 3'd1);
    send(4'd9, 64'h310, 64'h300, 64'd0, 1'b0);
    chk("ret_addr", mem_addr, 64'h300);
    chk("ret_we", 64'(mem_we), 64'd0);
    ack(64'hBEEF);

    // pushq out of range -> ADR, no request, stop
    expect_out(4'd10, 64'hFFC, 64'd0, 1'b0, 3'd3);
    send(4'd10, 64'hFFC, 64'h9, 64'd0, 1'b0);
    chk("push_no_req", 64'(mem_req), 64'd0);
    chk("push_valid", 64'(out_valid), 64'd1);
    check_stopped("push_stop");
    do_reset();

    // illegal icode
    expect_out(4'd12, 64'd7, 64'd0, 1'b1, 3'd4);
    send(4'd12, 64'd7, 64'd0, 64'd0, 1'b1);
    chk("ins_valid", 64'(out_valid), 64'd1);
    check_stopped("ins_stop");
    do_reset();

    // popq never acked -> timeout after 16 request cycles
    expect_out(4'd11, 64'h208, 64'd0, 1'b0, 3'd3);
    send(4'd11, 64'h208, 64'h200, 64'd0, 1'b0);
    chk("pop_addr", mem_addr, 64'h200);
    n = 0;
    while (mem_req && n < 40) begin
      n++;
      idle_cycles(1);
    end
    chk("pop_req_cycles", 64'(n), 64'd16);
    chk("pop_valid", 64'(out_valid), 64'd1);
    check_stopped("pop_stop");
    do_reset();

    // halt held by back-pressure
    out_ready = 1'b0;
    expect_out(4'd0, 64'h33, 64'd0, 1'b1, 3'd2);
    send(4'd0, 64'h33, 64'd0, 64'd0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("hlt_hold_valid", 64'(out_valid), 64'd1);
      chk("hlt_hold_stat", 64'(out_stat), 64'd2);
      chk("hlt_hold_valE", out_valE, 64'h33);
      chk("hlt_in_ready", 64'(in_ready), 64'd0);
      idle_cycles(1);
    end
    out_ready = 1'b1;
    idle_cycles(1);
    check_stopped("hlt_stop");
    do_reset();

    // reset in the middle of a request
    send(4'd5, 64'h80, 64'd0, 64'd0, 1'b0);
    chk("mid_req", 64'(mem_req), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", 64'(mem_req), 64'd0);
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    expect_out(4'd4, 64'hF00, 64'd0, 1'b0, 3'd1);
    send(4'd4, 64'hF00, 64'hABCD, 64'd0, 1'b0);
    chk("post_we", 64'(mem_we), 64'd1);
    chk("post_addr", mem_addr, 64'hF00);
    chk("post_wdata", mem_wdata, 64'hABCD);
    ack(64'd0);
    chk("post_valid", 64'(out_valid), 64'd1);

    idle_cycles(3);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/memory_access.md
# memory_access

Y86-64 memory stage: consumes the execute stage's result bundle (valE, cnd, operands) and performs the data-memory read or write each instruction requires. Drives a single-outstanding request/acknowledge data-memory port and presents valM plus a status code to writeback. Sits between execute and writeback, with valid/ready handshakes on both sides.

## Interface
Parameters:
- ADDR_LIMIT, 64'h1000, byte size of data memory; a quadword access is legal iff addr <= ADDR_LIMIT-8
- TIMEOUT, 16, max cycles to wait for mem_ack before declaring an address error

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  execute bundle valid
- in_ready  out  1  block can accept a bundle
- in_icode  in  4  instruction code
- in_valE  in  64  ALU result
- in_valA  in  64  register A value
- in_valP  in  64  next PC (return address for call)
- in_cnd  in  1  condition flag, passed through
- out_valid  out  1  result bundle valid
- out_ready  in  1  writeback accepts bundle
- out_icode  out  4  registered icode
- out_valE  out  64  registered valE
- out_valM  out  64  loaded data, 0 for non-loads
- out_cnd  out  1  registered cnd
- out_stat  out  3  1=AOK, 2=HLT, 3=ADR, 4=INS
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1=write, 0=read
- mem_addr  out  64  byte address
- mem_wdata  out  64  write data
- mem_ack  in  1  request complete (one-cycle pulse)
- mem_rdata  in  64  read data, valid with mem_ack

## Operation
- Per icode: 4 rmmovq write M[valE]=valA; 5 mrmovq read M[valE]; 8 call write M[valE]=valP; 9 ret read M[valA]; 10 pushq write M[valE]=valA; 11 popq read M[valA]; 1,2,3,6,7 no access; 0 halt -> stat HLT; icode >= 12 -> stat INS.
- Address out of range (addr > ADDR_LIMIT-8, unsigned) -> no request issued, stat ADR, valM=0.
- States: IDLE, MEM, DONE, STOP.
- IDLE: in_ready = !out_valid | out_ready. On accept: memory op with legal address -> MEM; otherwise load output registers, -> DONE.
- MEM: mem_req=1, mem_we/addr/wdata stable. On mem_ack: valM=mem_rdata for reads, 0 for writes, stat AOK -> DONE. Wait counter increments each MEM cycle; reaching TIMEOUT without ack -> stat ADR, drop mem_req -> DONE.
- DONE: out_valid=1, outputs stable until out_ready. Handshake with stat AOK -> IDLE; with stat != AOK -> STOP.
- STOP: in_ready=0, out_valid=0, mem_req=0 until reset.
- Reset (any state, including mid-MEM): all outputs 0, state IDLE, counter 0; a pending memory request is abandoned.

## Timing
- No-access instruction: accepted cycle t -> out_valid at t+1.
- Memory op: accepted t, mem_req high t+1; mem_ack at cycle a -> out_valid at a+1. Minimum latency 2 cycles (ack at t+1).
- mem_ack outside MEM is ignored. Ack in the same cycle the counter reaches TIMEOUT counts as success.
- Never more than one request outstanding; in_ready=0 throughout MEM and in DONE until out_ready.
- Back-to-back: out_ready high in DONE lets the next bundle be accepted in the same cycle only if the block has just returned to IDLE (i.e. one bubble minimum between bundles).

## Structure
- Shared package: icode constants (IHALT..IPOPQ), stat constants (SAOK, SHLT, SADR, SINS), FSM state enum.
- One natural sub-module: mem_op_decode (combinational icode -> is_read, is_write, addr_sel, wdata_sel, invalid).

## Test plan
- icode 6, valE=5, cnd=1 -> out_valid one cycle later, valE=5, valM=0, stat 1, no mem_req.
- mrmovq valE=0x100, ack after 3 cycles with rdata=0xDEAD -> mem_req/we=0/addr=0x100 held 3 cycles, valM=0xDEAD, stat 1.
- call valE=0x1F8, valP=0x40 -> write addr 0x1F8 data 0x40; pushq at valE=0xFFC -> stat 3, no request, then in_ready stays 0.
- popq valA=0x200, mem_ack never -> mem_req held 16 cycles, stat 3, block enters STOP.
- halt -> stat 2 after one cycle; out_ready held low 5 cycles -> outputs stable; later bundles refused.
- rst_n asserted mid-MEM -> mem_req, out_valid drop immediately; after release a fresh rmmovq completes normally.
